// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use and CSR/MRET serialisation stalls plus flush.
// Optional build macro HAZARD_STATS_EN adds saturating load-use / drain bubble counters.
module id_ex_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CSR_DRAIN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rdata1,
    input  logic [XLEN-1:0] id_rdata2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_aluop,
    input  logic [9:0]      id_ctrl,
    input  logic            id_is_mret,
    input  logic            flush,
    output logic            stall_id,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rdata1,
    output logic [XLEN-1:0] ex_rdata2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_aluop,
    output logic [9:0]      ex_ctrl,
    output logic            ex_is_mret
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]     stat_ldstall,
    output logic [31:0]     stat_drain
`endif
);

    localparam int unsigned CNT_W         = 3;
    localparam int unsigned CTRL_MEM_READ = 6;
    localparam int unsigned CTRL_CSR_WR   = 0;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    if (CSR_DRAIN < 1 || CSR_DRAIN > 7) begin : g_drain_check
        $error("id_ex_stage: CSR_DRAIN must be in 1..7");
    end

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               latch_c;
    logic               use_rs1_c, use_rs2_c, load_use_c, serial_c;

    // Source-register usage decode and load-use detection against the instruction in EX
    always_comb begin
        use_rs1_c  = !(id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
        use_rs2_c  = id_opcode inside {OP_R, OP_S, OP_B};
        load_use_c = id_valid && ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_rd != 5'd0) &&
                     ((use_rs1_c && (id_rs1 == ex_rd)) || (use_rs2_c && (id_rs2 == ex_rd)));
        serial_c   = id_valid && (id_ctrl[CTRL_CSR_WR] || id_is_mret);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Flush dominates; otherwise the state decides between latching ID and injecting a bubble
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        stall_id  = 1'b0;
        latch_c   = 1'b0;
        if (flush) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (load_use_c) begin
                        stall_id  = 1'b1;
                        state_nxt = LDSTALL;
                    end else begin
                        latch_c = 1'b1;
                        if (serial_c) begin
                            state_nxt = DRAIN;
                            cnt_nxt   = CNT_W'(CSR_DRAIN);
                        end
                    end
                end
                LDSTALL: begin
                    latch_c = 1'b1;
                    if (serial_c) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = CNT_W'(CSR_DRAIN);
                    end else begin
                        state_nxt = RUN;
                    end
                end
                DRAIN: begin
                    stall_id = 1'b1;
                    cnt_nxt  = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Bubbles clear only the control side; datapath fields keep stale values
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rdata1  <= '0;
            ex_rdata2  <= '0;
            ex_imm     <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_aluop   <= '0;
            ex_ctrl    <= '0;
            ex_is_mret <= 1'b0;
        end else if (latch_c && id_valid) begin
            ex_valid   <= 1'b1;
            ex_pc      <= id_pc;
            ex_rdata1  <= id_rdata1;
            ex_rdata2  <= id_rdata2;
            ex_imm     <= id_imm;
            ex_rs1     <= id_rs1;
            ex_rs2     <= id_rs2;
            ex_rd      <= id_rd;
            ex_aluop   <= id_aluop;
            ex_ctrl    <= id_ctrl;
            ex_is_mret <= id_is_mret;
        end else begin
            ex_valid   <= 1'b0;
            ex_aluop   <= '0;
            ex_ctrl    <= '0;
            ex_is_mret <= 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    logic ld_bubble_c, drain_bubble_c;

    assign ld_bubble_c    = !flush && (state_q == RUN) && load_use_c;
    assign drain_bubble_c = !flush && (state_q == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ldstall <= '0;
            stat_drain   <= '0;
        end else begin
            if (ld_bubble_c && (stat_ldstall != '1)) begin
                stat_ldstall <= stat_ldstall + 32'd1;
            end
            if (drain_bubble_c && (stat_drain != '1)) begin
                stat_drain <= stat_drain + 32'd1;
            end
        end
    end
`endif

endmodule
